// File: rtl/radar_frame_deframer.sv
// Strips FRST/LAST timestamp markers from a 64-bit sample stream and re-frames the data with tlast.
// Optional length check enabled by defining RADAR_DEFRAMER_MAXLEN_EN.
module radar_frame_deframer #(
  parameter int MAX_WORDS = 32768,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 axi_tclk,
  input  logic                 axi_tresetn,
  input  logic [63:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [63:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [31:0]          frame_start_ts,
  output logic [31:0]          frame_end_ts,
  output logic [LEN_WIDTH-1:0] frame_len,
  output logic                 frame_done,
  output logic [LEN_WIDTH-1:0] frame_cnt,
  output logic                 err_orphan_last,
  output logic                 err_missing_last,
  output logic                 err_empty,
  output logic                 err_overflow
);

  localparam logic [31:0] FRST_MARK = 32'h4652_5354;
  localparam logic [31:0] LAST_MARK = 32'h4C41_5354;

  typedef enum logic {HUNT, DATA} state_t;

  state_t               state_reg;
  logic [63:0]          hold_data_reg;
  logic                 hold_valid_reg;
  logic [LEN_WIDTH-1:0] word_cnt_reg;

  logic is_frst;
  logic is_last;
  logic out_free;
  logic s_fire;
  logic over_limit;
  logic unused_tlast;

  assign is_frst       = (s_axis_tdata[31:0] == FRST_MARK);
  assign is_last       = (s_axis_tdata[31:0] == LAST_MARK);
  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state_reg == HUNT) || out_free;
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  // Framing comes only from the in-band markers.
  assign unused_tlast  = s_axis_tlast;

`ifdef RADAR_DEFRAMER_MAXLEN_EN
  localparam logic [LEN_WIDTH:0] MAX_W = (LEN_WIDTH+1)'(MAX_WORDS);
  assign over_limit = ({1'b0, word_cnt_reg} >= MAX_W);
`else
  assign over_limit = 1'b0;
`endif

  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn) begin
      state_reg        <= HUNT;
      hold_data_reg    <= '0;
      hold_valid_reg   <= 1'b0;
      word_cnt_reg     <= '0;
      m_axis_tdata     <= '0;
      m_axis_tvalid    <= 1'b0;
      m_axis_tlast     <= 1'b0;
      frame_start_ts   <= '0;
      frame_end_ts     <= '0;
      frame_len        <= '0;
      frame_done       <= 1'b0;
      frame_cnt        <= '0;
      err_orphan_last  <= 1'b0;
      err_missing_last <= 1'b0;
      err_empty        <= 1'b0;
      err_overflow     <= 1'b0;
    end else begin
      frame_done       <= 1'b0;
      err_orphan_last  <= 1'b0;
      err_missing_last <= 1'b0;
      err_empty        <= 1'b0;
      err_overflow     <= 1'b0;
      // A consumed beat frees O; any load below overrides this.
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (s_fire) begin
        case (state_reg)
          HUNT: begin
            if (is_frst) begin
              frame_start_ts <= s_axis_tdata[63:32];
              word_cnt_reg   <= '0;
              hold_valid_reg <= 1'b0;
              state_reg      <= DATA;
            end else if (is_last) begin
              err_orphan_last <= 1'b0 | 1'b1;
            end
          end
          DATA: begin
            if (is_frst) begin
              err_missing_last <= 1'b1;
              if (hold_valid_reg) begin
                m_axis_tdata  <= hold_data_reg;
                m_axis_tlast  <= 1'b1;
                m_axis_tvalid <= 1'b1;
              end
              hold_valid_reg <= 1'b0;
              frame_start_ts <= s_axis_tdata[63:32];
              word_cnt_reg   <= '0;
            end else if (is_last) begin
              if (hold_valid_reg) begin
                m_axis_tdata  <= hold_data_reg;
                m_axis_tlast  <= 1'b1;
                m_axis_tvalid <= 1'b1;
              end
              hold_valid_reg <= 1'b0;
              frame_end_ts   <= s_axis_tdata[63:32];
              frame_len      <= word_cnt_reg;
              frame_done     <= 1'b1;
              frame_cnt      <= frame_cnt + 1'b1;
              err_empty      <= (word_cnt_reg == '0);
              state_reg      <= HUNT;
            end else if (over_limit) begin
              // Oversized frame: close what we have and drop the offending word.
              if (hold_valid_reg) begin
                m_axis_tdata  <= hold_data_reg;
                m_axis_tlast  <= 1'b1;
                m_axis_tvalid <= 1'b1;
              end
              hold_valid_reg <= 1'b0;
              err_overflow   <= 1'b1;
              state_reg      <= HUNT;
            end else begin
              if (hold_valid_reg) begin
                m_axis_tdata  <= hold_data_reg;
                m_axis_tlast  <= 1'b0;
                m_axis_tvalid <= 1'b1;
              end
              hold_data_reg  <= s_axis_tdata;
              hold_valid_reg <= 1'b1;
              if (word_cnt_reg != '1) begin
                word_cnt_reg <= word_cnt_reg + 1'b1;
              end
            end
          end
          default: state_reg <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_radar_frame_deframer.sv
// Directed bench for radar_frame_deframer: marker framing, backpressure, error pulses, reset abort.
module tb_radar_frame_deframer;

  logic        axi_tclk = 1'b0;
  logic        axi_tresetn;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [31:0] frame_start_ts;
  logic [31:0] frame_end_ts;
  logic [15:0] frame_len;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        err_orphan_last;
  logic        err_missing_last;
  logic        err_empty;
  logic        err_overflow;

  always #5 axi_tclk = ~axi_tclk;

  radar_frame_deframer #(.MAX_WORDS(8), .LEN_WIDTH(16)) dut (
    .axi_tclk        (axi_tclk),
    .axi_tresetn     (axi_tresetn),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .frame_start_ts  (frame_start_ts),
    .frame_end_ts    (frame_end_ts),
    .frame_len       (frame_len),
    .frame_done      (frame_done),
    .frame_cnt       (frame_cnt),
    .err_orphan_last (err_orphan_last),
    .err_missing_last(err_missing_last),
    .err_empty       (err_empty),
    .err_overflow    (err_overflow)
  );

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } beat_t;

  beat_t beat_q[$];
  beat_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt, orphan_cnt, missing_cnt, empty_cnt, ovf_cnt;
  int exp_fcnt = 0;
  logic bp_en  = 1'b0;
  logic bp_chk = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] frst(input logic [31:0] ts);
    return {ts, 32'h4652_5354};
  endfunction

  function automatic logic [63:0] lst(input logic [31:0] ts);
    return {ts, 32'h4C41_5354};
  endfunction

  function automatic logic [63:0] dw(input int base, input int i);
    return {32'hDA7A_0000 + 32'(base), 32'(i)};
  endfunction

  // Monitor samples one time unit before each rising edge.
  initial forever begin
    @(negedge axi_tclk);
    #4;
    if (axi_tresetn === 1'b1) begin
      if (prev_stall) begin
        check("hold_valid", 64'(m_axis_tvalid), 64'd1);
        check("hold_data", m_axis_tdata, prev_data);
        check("hold_last", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (bp_chk) check("s_ready_bp", 64'(s_axis_tready), 64'(!m_axis_tvalid || m_axis_tready));
      if (m_axis_tvalid && m_axis_tready) beat_q.push_back('{d: m_axis_tdata, l: m_axis_tlast});
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (frame_done)       done_cnt++;
      if (err_orphan_last)  orphan_cnt++;
      if (err_missing_last) missing_cnt++;
      if (err_empty)        empty_cnt++;
      if (err_overflow)     ovf_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial forever begin
    @(negedge axi_tclk);
    if (bp_en) m_axis_tready = ~m_axis_tready;
  end

  task automatic send(input logic [63:0] w);
    bit ok = 0;
    int n = 0;
    while (!ok) begin
      @(negedge axi_tclk);
      s_axis_tdata  = w;
      s_axis_tvalid = 1'b1;
      #1;
      if (s_axis_tready) ok = 1;
      else if (++n > 200) begin
        check("send_timeout", 64'd0, 64'd1);
        ok = 1;
      end
    end
    @(posedge axi_tclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge axi_tclk);
  endtask

  task automatic clear_pulses();
    done_cnt = 0; orphan_cnt = 0; missing_cnt = 0; empty_cnt = 0; ovf_cnt = 0;
  endtask

  task automatic compare_beats(input string tag);
    check({tag, "_beats"}, 64'(beat_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_d%0d", tag, i), beat_q[i].d, exp_q[i].d);
      check($sformatf("%s_l%0d", tag, i), 64'(beat_q[i].l), 64'(exp_q[i].l));
    end
    beat_q.delete();
    exp_q.delete();
  endtask

  initial begin
    axi_tresetn   = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    clear_pulses();
    #23;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_fcnt", 64'(frame_cnt), 64'd0);
    check("rst_flen", 64'(frame_len), 64'd0);
    check("rst_ts", {frame_start_ts, frame_end_ts}, 64'd0);
    check("rst_pulses", 64'({frame_done, err_orphan_last, err_missing_last, err_empty, err_overflow}), 64'd0);
    @(negedge axi_tclk);
    axi_tresetn = 1'b1;
    @(posedge axi_tclk);
    #1;
    check("ready_after_rst", 64'(s_axis_tready), 64'd1);

    // Normal frame; D0 must sit in the hold register until the next word.
    send(frst(32'h100));
    send(dw(1, 0));
    idle(2);
    check("n_d0_held", 64'(m_axis_tvalid), 64'd0);
    for (int i = 1; i < 4; i++) send(dw(1, i));
    send(lst(32'h108));
    idle(4);
    exp_fcnt++;
    for (int i = 0; i < 4; i++) exp_q.push_back('{d: dw(1, i), l: (i == 3)});
    compare_beats("normal");
    check("n_start_ts", 64'(frame_start_ts), 64'h100);
    check("n_end_ts", 64'(frame_end_ts), 64'h108);
    check("n_len", 64'(frame_len), 64'd4);
    check("n_done", 64'(done_cnt), 64'd1);
    check("n_fcnt", 64'(frame_cnt), 64'(exp_fcnt));
    clear_pulses();

    // Same frame with the sink toggling ready every cycle.
    bp_en = 1'b1;
    send(frst(32'h100));
    bp_chk = 1'b1;
    for (int i = 0; i < 4; i++) send(dw(2, i));
    send(lst(32'h108));
    bp_chk = 1'b0;
    idle(8);
    bp_en = 1'b0;
    m_axis_tready = 1'b1;
    idle(2);
    exp_fcnt++;
    for (int i = 0; i < 4; i++) exp_q.push_back('{d: dw(2, i), l: (i == 3)});
    compare_beats("bp");
    check("bp_len", 64'(frame_len), 64'd4);
    check("bp_done", 64'(done_cnt), 64'd1);
    check("bp_fcnt", 64'(frame_cnt), 64'(exp_fcnt));
    clear_pulses();

    // LAST while hunting.
    send(lst(32'h5));
    idle(3);
    compare_beats("orphan");
    check("o_err", 64'(orphan_cnt), 64'd1);
    check("o_done", 64'(done_cnt), 64'd0);
    check("o_fcnt", 64'(frame_cnt), 64'(exp_fcnt));
    clear_pulses();

    // FRST inside a frame.
    send(frst(32'h1F0));
    send(dw(3, 0));
    send(dw(3, 1));
    send(frst(32'h200));
    send(dw(3, 2));
    send(lst(32'h210));
    idle(4);
    exp_fcnt++;
    exp_q.push_back('{d: dw(3, 0), l: 1'b0});
    exp_q.push_back('{d: dw(3, 1), l: 1'b1});
    exp_q.push_back('{d: dw(3, 2), l: 1'b1});
    compare_beats("missing");
    check("m_err", 64'(missing_cnt), 64'd1);
    check("m_start_ts", 64'(frame_start_ts), 64'h200);
    check("m_len", 64'(frame_len), 64'd1);
    check("m_done", 64'(done_cnt), 64'd1);
    check("m_fcnt", 64'(frame_cnt), 64'(exp_fcnt));
    clear_pulses();

    // Empty frame.
    send(frst(32'h300));
    send(lst(32'h301));
    idle(3);
    exp_fcnt++;
    compare_beats("empty");
    check("e_err", 64'(empty_cnt), 64'd1);
    check("e_done", 64'(done_cnt), 64'd1);
    check("e_len", 64'(frame_len), 64'd0);
    check("e_fcnt", 64'(frame_cnt), 64'(exp_fcnt));
    clear_pulses();

    // Nine data words against MAX_WORDS=8.
    send(frst(32'h500));
    for (int i = 0; i < 9; i++) send(dw(4, i));
    send(lst(32'h509));
    idle(4);
`ifdef RADAR_DEFRAMER_MAXLEN_EN
    for (int i = 0; i < 8; i++) exp_q.push_back('{d: dw(4, i), l: (i == 7)});
    compare_beats("ovf");
    check("ov_err", 64'(ovf_cnt), 64'd1);
    check("ov_done", 64'(done_cnt), 64'd0);
    check("ov_orphan", 64'(orphan_cnt), 64'd1);
`else
    exp_fcnt++;
    for (int i = 0; i < 9; i++) exp_q.push_back('{d: dw(4, i), l: (i == 8)});
    compare_beats("ovf");
    check("ov_err", 64'(ovf_cnt), 64'd0);
    check("ov_len", 64'(frame_len), 64'd9);
    check("ov_done", 64'(done_cnt), 64'd1);
`endif
    check("ov_fcnt", 64'(frame_cnt), 64'(exp_fcnt));
    clear_pulses();

    // Reset with D0 stalled in O and D1 in H.
    @(negedge axi_tclk);
    m_axis_tready = 1'b0;
    send(frst(32'h600));
    send(dw(5, 0));
    send(dw(5, 1));
    check("r_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
    #2;
    axi_tresetn = 1'b0;
    #1;
    check("r_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("r_tlast", 64'(m_axis_tlast), 64'd0);
    check("r_fcnt0", 64'(frame_cnt), 64'd0);
    @(negedge axi_tclk);
    axi_tresetn = 1'b1;
    m_axis_tready = 1'b1;
    beat_q.delete();
    clear_pulses();
    send(frst(32'h400));
    send(dw(6, 0));
    send(lst(32'h401));
    idle(4);
    exp_q.push_back('{d: dw(6, 0), l: 1'b1});
    compare_beats("reset");
    check("r_len", 64'(frame_len), 64'd1);
    check("r_fcnt", 64'(frame_cnt), 64'd1);
    check("r_done", 64'(done_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/radar_frame_deframer.md
RADAR_FRAME_DEFRAMER -- requirements
Module: radar_frame_deframer

Interface
REQ-001 Parameter MAX_WORDS, default 32768: maximum data words per frame, used by the length check.
REQ-002 Parameter LEN_WIDTH, default 16: width of the length and frame-count outputs.
REQ-003 Port axi_tclk, input, 1: single clock for all logic.
REQ-004 Port axi_tresetn, input, 1: reset, asynchronous and active-low.
REQ-005 Ports s_axis_tdata [63:0], s_axis_tvalid, s_axis_tlast (inputs) and s_axis_tready (output): framed sample stream in.
REQ-006 Ports m_axis_tdata [63:0], m_axis_tvalid, m_axis_tlast (outputs) and m_axis_tready (input): deframed sample stream out.
REQ-007 Outputs frame_start_ts [31:0] and frame_end_ts [31:0]: timestamps from the FRST and LAST markers.
REQ-008 Output frame_len [LEN_WIDTH-1:0]: count of data words in the last completed frame.
REQ-009 Output frame_done, 1 bit: one-cycle pulse when a frame completes.
REQ-010 Output frame_cnt [LEN_WIDTH-1:0]: count of completed frames; wraps.
REQ-011 Outputs err_orphan_last, err_missing_last, err_empty, err_overflow, 1 bit each: one-cycle error pulses.

Function
REQ-012 Marker decode: FRST when tdata[31:0]==32'h46525354; LAST when tdata[31:0]==32'h4C415354; the timestamp is tdata[63:32]. Input s_axis_tlast is ignored.
REQ-013 States:
- HUNT (reset state)
- DATA
REQ-014 HUNT behaviour:
- s_axis_tready=1; every non-FRST word is dropped.
- FRST: latch frame_start_ts, clear the word count, clear hold-valid, go to DATA.
REQ-015 A LAST word accepted in HUNT shall be dropped and shall pulse err_orphan_last.
REQ-016 DATA holds one word in a hold register H (hold_valid) so that m_axis_tlast lands on the final data word.
REQ-017 Output register O drives m_axis_*. In DATA, s_axis_tready = !m_axis_tvalid | m_axis_tready.
REQ-018 Data word accepted in DATA:
- If hold_valid, H moves to O with tlast=0.
- The new word loads into H; the word count increments.
REQ-019 LAST accepted in DATA:
- If hold_valid, H moves to O with tlast=1.
- Latch frame_end_ts; frame_len = count.
- Next cycle: pulse frame_done, increment frame_cnt.
- Go to HUNT.
REQ-020 A LAST with count==0 shall additionally pulse err_empty; no output beat is produced.
REQ-021 FRST accepted in DATA shall pulse err_missing_last and flush H with tlast=1 (no frame_done), then restart: new frame_start_ts, count=0, stay in DATA.
REQ-022 O follows AXI-stream rules: tvalid holds until tready; tdata and tlast stay stable while tvalid=1 and tready=0.
REQ-023 Latency: a data word appears on m_axis one accepted word after it enters, or the cycle after LAST/flush; no combinational path from s_axis to m_axis.
REQ-024 Counters: word count saturates at 2^LEN_WIDTH-1; frame_cnt wraps to 0.

Reset
REQ-025 Asserting axi_tresetn low asynchronously forces:
- state=HUNT, hold_valid=0
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0
- all counts, timestamps, frame_len, frame_done and err_* = 0
REQ-026 After axi_tresetn is released, s_axis_tready shall be 1 from the first clock edge.
REQ-027 Reset asserted mid-frame shall discard H and O contents; no tlast is emitted for the aborted frame.

Configuration
REQ-028 Macro RADAR_DEFRAMER_MAXLEN_EN, when defined: a data word that would make count exceed MAX_WORDS is dropped and shall:
- flush H with tlast=1
- pulse err_overflow
- go to HUNT with no frame_done
REQ-029 When RADAR_DEFRAMER_MAXLEN_EN is not defined: no length check; err_overflow is tied to 0; count saturates per REQ-024.

Verification
REQ-030 Normal frame: FRST(ts=0x100), data D0..D3, LAST(ts=0x108), m_axis_tready=1 -> 4 beats, tlast only on D3; frame_start_ts=0x100, frame_end_ts=0x108, frame_len=4, one frame_done pulse, frame_cnt=1.
REQ-031 Backpressure: same frame with m_axis_tready toggling 1/0 every cycle -> identical beat order and data; s_axis_tready low whenever O is full and stalled; no beat lost or duplicated.
REQ-032 Markers out of place: LAST in HUNT -> err_orphan_last pulse, no output. FRST, D0, D1, FRST(ts=0x200), D2, LAST -> err_missing_last; beats D0, D1(tlast) then D2(tlast); frame_start_ts=0x200, frame_len=1.
REQ-033 Empty frame: FRST immediately followed by LAST -> err_empty and frame_done pulse, frame_len=0, no m_axis beat.
REQ-034 With RADAR_DEFRAMER_MAXLEN_EN and MAX_WORDS=8: FRST then 9 data words -> 8 beats, tlast on the 8th, err_overflow pulse, return to HUNT. Without the macro: 9 words pass and err_overflow stays 0.
REQ-035 Reset mid-frame after 2 data words -> m_axis_tvalid=0 immediately; the next FRST/D0/LAST frame yields frame_len=1 and frame_cnt=1.
